// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;

   // Bit counter width: enough to index bits 0..w-1, never less than one bit.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: difference and borrow for a single bit position.
module sub_bit_cell (
   input  logic minuend,
   input  logic subtrahend,
   input  logic borrow_in,
   output logic difference,
   output logic borrow_out
);

   logic prop;

   assign prop       = minuend ^ subtrahend;
   assign difference = prop ^ borrow_in;
   assign borrow_out = (~minuend & subtrahend) | (~prop & borrow_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: a - b computed LSB first, one bit per cycle,
// with a registered result and a one-cycle done pulse.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow_q;
   logic [CNT_W-1:0] cnt;

   logic             cell_d;
   logic             cell_bout;
   logic [WIDTH-1:0] res_nxt;

   sub_bit_cell u_cell (
      .minuend    (a_sr[0]),
      .subtrahend (b_sr[0]),
      .borrow_in  (borrow_q),
      .difference (cell_d),
      .borrow_out (cell_bout)
   );

   // New difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   assign res_nxt = {cell_d, res_sr[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         borrow_q   <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  res_sr   <= '0;
                  borrow_q <= 1'b0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr     <= a_sr >> 1;
               b_sr     <= b_sr >> 1;
               res_sr   <= res_nxt;
               borrow_q <= cell_bout;
               cnt      <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  diff       <= res_nxt;
                  borrow_out <= cell_bout;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
